// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Optional long-press detection is enabled with DEBOUNCE_LONGPRESS_EN.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHANGE = 1'b1
    } deb_state_t;

    // Converts a time in ms at a clock in MHz into a cycle count.
    function automatic int calc_cycles(input int freq_mhz, input int ms);
        return freq_mhz * 1000 * ms;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stable-time qualifier, edge pulses and,
// with DEBOUNCE_LONGPRESS_EN defined, a saturating long-press hold counter.
//
// state     | meaning
// ST_STABLE | synchronised input matches o_level, counter idle
// ST_CHANGE | counting consecutive samples that differ from o_level
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned DELAY_CYC   = 8,
`ifdef DEBOUNCE_LONGPRESS_EN
    parameter int unsigned LONG_CYC    = 32,
`endif
    parameter int          SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);

    localparam int CW = $clog2(DELAY_CYC + 1);
    localparam logic [CW-1:0] TC = CW'(DELAY_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    deb_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    deb_state_t             w_state_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_flip;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= r_level ^ w_flip;
            r_rise  <= w_flip & ~r_level;
            r_fall  <= w_flip & r_level;
        end
    end

    // The counter holds the number of new-value samples seen so far, so the
    // D-th sample is recognised while the counter still reads D-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flip      = 1'b0;
        unique case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (w_s != r_level) begin
                    if (DELAY_CYC <= 1) begin
                        w_flip = 1'b1;
                    end else begin
                        w_state_nxt = ST_CHANGE;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            ST_CHANGE: begin
                if (w_s == r_level) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= TC) begin
                    w_flip      = 1'b1;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYC + 1);

    logic [LW-1:0] r_hold;
    logic          r_long;

    // Saturates at LONG_CYC so the pulse fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!r_level) begin
                r_hold <= '0;
            end else if (r_hold != LW'(LONG_CYC)) begin
                r_hold <= r_hold + 1'b1;
                r_long <= (r_hold == LW'(LONG_CYC - 1));
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CH independent debounce_chan instances.
// Long-press pulses are generated only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int          CH            = 4,
    parameter int          DELAY_MS      = 50,
    parameter int          FREQ_MHZ      = 25,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [CH-1:0] RST_VAL     = '0,
    parameter int          SIM_DELAY_CYC = 0
`ifdef DEBOUNCE_LONGPRESS_EN
    ,
    parameter int          LONG_MS       = 1000
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] i_sig,
    output logic [CH-1:0] o_level,
    output logic [CH-1:0] o_rise,
    output logic [CH-1:0] o_fall,
    output logic [CH-1:0] o_long
);

    localparam int unsigned DELAY_CYC = (SIM_DELAY_CYC != 0) ?
        32'(SIM_DELAY_CYC) : 32'(calc_cycles(FREQ_MHZ, DELAY_MS));

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int unsigned LONG_CYC = (SIM_DELAY_CYC != 0) ?
        32'(4 * SIM_DELAY_CYC) : 32'(calc_cycles(FREQ_MHZ, LONG_MS));
`endif

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        debounce_chan #(
            .DELAY_CYC   (DELAY_CYC),
`ifdef DEBOUNCE_LONGPRESS_EN
            .LONG_CYC    (LONG_CYC),
`endif
            .SYNC_STAGES (SYNC_STAGES),
            .RST_VAL     (RST_VAL[gi])
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_sig   (i_sig[gi]),
            .o_level (o_level[gi]),
            .o_rise  (o_rise[gi]),
            .o_fall  (o_fall[gi]),
            .o_long  (o_long[gi])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (SIM_DELAY_CYC=8, two sync stages, 4 channels).
// Expectations adapt to DEBOUNCE_LONGPRESS_EN when the macro is defined.
module tb_debounce_multi;

    localparam int CH = 4;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] i_sig;
    logic [CH-1:0] o_level;
    logic [CH-1:0] o_rise;
    logic [CH-1:0] o_fall;
    logic [CH-1:0] o_long;

    int n_chk;
    int n_err;

    int rise_cnt [CH];
    int fall_cnt [CH];
    int long_cnt [CH];
    int both_cnt;

    int s_rise [CH];
    int s_fall [CH];
    int s_long [CH];

    debounce_multi #(
        .CH            (CH),
        .DELAY_MS      (50),
        .FREQ_MHZ      (25),
        .SYNC_STAGES   (2),
        .RST_VAL       (4'h0),
        .SIM_DELAY_CYC (8)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sig   (i_sig),
        .o_level (o_level),
        .o_rise  (o_rise),
        .o_fall  (o_fall),
        .o_long  (o_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse accounting on the falling edge, mid-way between register updates.
    initial begin
        both_cnt = 0;
        for (int i = 0; i < CH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            long_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            rise_cnt[i] += int'(o_rise[i]);
            fall_cnt[i] += int'(o_fall[i]);
            long_cnt[i] += int'(o_long[i]);
            if (o_rise[i] && o_fall[i]) both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        for (int i = 0; i < CH; i++) begin
            s_rise[i] = rise_cnt[i];
            s_fall[i] = fall_cnt[i];
            s_long[i] = long_cnt[i];
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        i_sig = 4'hF;

        // Reset with all inputs high
        tick(3);
        chk("rst_level", 32'(o_level), 32'h0);
        chk("rst_rise",  32'(o_rise),  32'h0);
        chk("rst_fall",  32'(o_fall),  32'h0);
        chk("rst_long",  32'(o_long),  32'h0);
        snap();
        rst_n = 1'b1;
        tick(9);
        chk("rel_level_c9", 32'(o_level), 32'h0);
        tick(1);
        chk("rel_level_c10", 32'(o_level), 32'hF);
        chk("rel_rise_c10",  32'(o_rise),  32'hF);
        tick(1);
        chk("rel_rise_c11", 32'(o_rise), 32'h0);
        for (int i = 0; i < CH; i++) chk("rel_rise_count", 32'(rise_cnt[i] - s_rise[i]), 32'd1);

        // All channels back to 0 together
        i_sig = 4'h0;
        tick(10);
        chk("all_fall_c10", 32'(o_fall),  32'hF);
        chk("all_lvl_c10",  32'(o_level), 32'h0);
        tick(2);

        // Clean step on ch0
        snap();
        i_sig[0] = 1'b1;
        tick(9);
        chk("step_lvl_c9", 32'(o_level[0]), 32'd0);
        tick(1);
        chk("step_lvl_c10",  32'(o_level), 32'h1);
        chk("step_rise_c10", 32'(o_rise),  32'h1);
        tick(1);
        chk("step_rise_c11",  32'(o_rise[0]), 32'd0);
        chk("step_fall_none", 32'(fall_cnt[0] - s_fall[0]), 32'd0);
        i_sig[0] = 1'b0;
        tick(12);
        chk("step_back_lvl", 32'(o_level[0]), 32'd0);

        // Bounce on ch1: 7 high, 1 low, then high
        snap();
        i_sig[1] = 1'b1;
        tick(7);
        i_sig[1] = 1'b0;
        tick(1);
        i_sig[1] = 1'b1;
        tick(9);
        chk("bounce_lvl_c9",   32'(o_level[1]), 32'd0);
        chk("bounce_no_early", 32'(rise_cnt[1] - s_rise[1]), 32'd0);
        tick(1);
        chk("bounce_lvl_c10",  32'(o_level[1]), 32'd1);
        chk("bounce_rise_c10", 32'(o_rise[1]),  32'd1);
        tick(4);
        chk("bounce_one_rise", 32'(rise_cnt[1] - s_rise[1]), 32'd1);
        i_sig[1] = 1'b0;
        tick(12);
        chk("bounce_back_lvl", 32'(o_level[1]), 32'd0);

        // Chatter on ch2
        snap();
        for (int k = 0; k < 100; k++) begin
            i_sig[2] = ~i_sig[2];
            tick(1);
        end
        i_sig[2] = 1'b0;
        tick(4);
        chk("chatter_lvl",  32'(o_level[2]), 32'd0);
        chk("chatter_rise", 32'(rise_cnt[2] - s_rise[2]), 32'd0);
        chk("chatter_fall", 32'(fall_cnt[2] - s_fall[2]), 32'd0);

        // Async reset while ch3 is mid-qualification and ch0 is high
        i_sig[0] = 1'b1;
        tick(12);
        chk("pre_rst_lvl", 32'(o_level), 32'h1);
        i_sig = 4'b1000;
        tick(7);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", 32'(o_level), 32'h0);
        chk("midrst_rise",  32'(o_rise),  32'h0);
        chk("midrst_fall",  32'(o_fall),  32'h0);
        i_sig = 4'h0;
        tick(2);
        snap();
        rst_n = 1'b1;
        tick(15);
        chk("postrst_level", 32'(o_level), 32'h0);
        for (int i = 0; i < CH; i++) begin
            chk("postrst_rise", 32'(rise_cnt[i] - s_rise[i]), 32'd0);
            chk("postrst_fall", 32'(fall_cnt[i] - s_fall[i]), 32'd0);
        end

        // Long press on ch3
        snap();
        i_sig[3] = 1'b1;
        tick(10);
        chk("lp_rise", 32'(o_rise), 32'h8);
        tick(31);
        chk("lp_long_c31", 32'(o_long[3]), 32'd0);
        tick(1);
        chk("lp_long_c32", 32'(o_long[3]), 32'(LONG_EN));
        tick(1);
        chk("lp_long_c33", 32'(o_long[3]), 32'd0);
        tick(40);
        chk("lp_long_once", 32'(long_cnt[3] - s_long[3]), 32'(LONG_EN));
        i_sig[3] = 1'b0;
        tick(12);
        chk("lp_release_lvl", 32'(o_level[3]), 32'd0);

        for (int i = 0; i < 3; i++) chk("long_other", 32'(long_cnt[i]), 32'd0);
        chk("rise_fall_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
